mem_align_unit: RTL

Parametrised load/store alignment engine between the MEM stage and the data-memory bus. It derives byte enables for byte/half/word/doubleword accesses, shifts store data into lanes, and sign- or zero-extends load data. It supersedes the fixed 32-bit byte-enable decode with configurable bus width and optional misaligned-access support, which splits an access into two bus beats over a valid/ack handshake.

---
 rtl/mem_align_unit.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/mem_align_unit.sv
// Load/store alignment engine between the MEM stage and the data bus: byte enables,
// store lane shifting, load extension, and optional two-beat splitting of lane-crossing accesses.
module mem_align_unit #(
  parameter int DW             = 32,
  parameter int AW             = 32,
  parameter bit ALLOW_MISALIGN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_signed,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW-1:0]   req_wdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW/8-1:0] mem_be,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_ack,
  input  logic [DW-1:0]   mem_rdata,
  output logic            resp_valid,
  output logic            resp_err,
  output logic [DW-1:0]   resp_rdata
);

  localparam int NB = DW / 8;
  localparam int OB = $clog2(NB);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;
  state_t state;

  logic            we_q, signed_q, split_q;
  logic [1:0]      size_q;
  logic [OB-1:0]   off_q;
  logic [NB-1:0]   be1_q;
  logic [DW-1:0]   wdata1_q, buf_lo_q;

  logic [OB-1:0]   off;
  logic [2*NB-1:0] base, mask;
  logic [2*DW-1:0] wide_raw, wide;
  logic            split, size_bad, reject;
  logic [AW-1:0]   addr0;

  assign req_ready = (state == IDLE);
  assign off       = req_addr[OB-1:0];
  assign size_bad  = (req_size == 2'd3) && (DW != 64);
  assign addr0     = {req_addr[AW-1:OB], {OB{1'b0}}};

  // Byte mask of the access spread over two bus words; the upper word is the second beat.
  always_comb begin
    base = '0;
    for (int i = 0; i < 8; i++)
      if (i < (1 << req_size)) base[i] = 1'b1;
  end

  assign mask     = base << off;
  assign split    = |mask[2*NB-1:NB];
  assign reject   = size_bad || (split && !ALLOW_MISALIGN);
  assign wide_raw = {{DW{1'b0}}, req_wdata} << (8 * off);

  always_comb begin
    wide = '0;
    for (int i = 0; i < 2*NB; i++)
      if (req_we && mask[i]) wide[8*i +: 8] = wide_raw[8*i +: 8];
  end

  logic [2*DW-1:0] full;
  logic [DW-1:0]   low, keep, top, load_data;
  logic            sign;
  int              nbits;

  // Load extraction works on the final beat's data combined with the buffered first beat.
  always_comb begin
    full = {{DW{1'b0}}, mem_rdata};
    if (state == BEAT1) full = {mem_rdata, buf_lo_q};
    low       = DW'(full >> (8 * off_q));
    nbits     = 8 << size_q;
    keep      = (nbits >= DW) ? '1 : ((DW'(1) << nbits) - DW'(1));
    top       = keep & ~(keep >> 1);
    sign      = signed_q && (|(low & top));
    load_data = (low & keep) | ({DW{sign}} & ~keep);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      we_q       <= 1'b0;
      signed_q   <= 1'b0;
      split_q    <= 1'b0;
      size_q     <= '0;
      off_q      <= '0;
      be1_q      <= '0;
      wdata1_q   <= '0;
      buf_lo_q   <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          we_q     <= req_we;
          signed_q <= req_signed;
          size_q   <= req_size;
          off_q    <= off;
          split_q  <= split;
          be1_q    <= mask[2*NB-1:NB];
          wdata1_q <= wide[2*DW-1:DW];
          if (reject) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end else begin
            state     <= BEAT0;
            mem_req   <= 1'b1;
            mem_we    <= req_we;
            mem_addr  <= addr0;
            mem_be    <= mask[NB-1:0];
            mem_wdata <= wide[DW-1:0];
          end
        end
        BEAT0, BEAT1: if (mem_ack) begin
          if (state == BEAT0) buf_lo_q <= mem_rdata;
          // The second beat address wraps naturally at the top of the address space.
          if (state == BEAT0 && split_q) begin
            state     <= BEAT1;
            mem_addr  <= mem_addr + AW'(NB);
            mem_be    <= be1_q;
            mem_wdata <= wdata1_q;
          end else begin
            state      <= RESP;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= we_q ? '0 : load_data;
          end
        end
        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
